// File: rtl/elevator_if.sv
// Call/status bundle between the elevator controller and its board-side
// neighbours: call buttons in, floor digit / pending LEDs / motion flags out.
interface elevator_if #(
    parameter int NUM_FLOORS = 6
);
    logic [NUM_FLOORS-1:0] call_req;   // per-floor call, level or pulse
    logic [3:0]            floor_bcd;  // current floor, one BCD digit
    logic [NUM_FLOORS-1:0] pending;    // latched calls not yet serviced
    logic                  dir_up;     // car travelling upwards
    logic                  dir_down;   // car travelling downwards
    logic                  door_open;  // door held open at current floor

    // Side that issues calls and watches the car (board glue / testbench).
    modport master (
        output call_req,
        input  floor_bcd,
        input  pending,
        input  dir_up,
        input  dir_down,
        input  door_open
    );

    // The controller itself.
    modport slave (
        input  call_req,
        output floor_bcd,
        output pending,
        output dir_up,
        output dir_down,
        output door_open
    );
endinterface

// File: rtl/elevator_ctrl.sv
// Elevator car controller: latches floor calls, moves the car one floor at a
// time using LOOK scheduling, and holds the door open at each serviced floor.
// All outputs come straight from registers or the state decode, so nothing
// combinational runs from call_req to the board LEDs / seven-segment digit.
module elevator_ctrl #(
    parameter int NUM_FLOORS  = 6,
    parameter int MOVE_CYCLES = 4,
    parameter int DOOR_CYCLES = 3
) (
    input  logic       clk,
    input  logic       reset,
    elevator_if.slave  bus
);

    localparam int FW      = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1;
    localparam int MAX_CYC = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
    localparam int TW      = $clog2(MAX_CYC + 1);

    localparam logic [FW-1:0] FLOOR_TOP = FW'(NUM_FLOORS - 1);
    localparam logic [TW-1:0] MOVE_LAST = TW'(MOVE_CYCLES - 1);
    localparam logic [TW-1:0] DOOR_LAST = TW'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_MOVE_UP   = 2'd1,
        S_MOVE_DOWN = 2'd2,
        S_DOOR      = 2'd3
    } state_t;

    state_t                state_q,    state_d;
    logic [FW-1:0]         floor_q,    floor_d;
    logic [TW-1:0]         timer_q,    timer_d;
    logic                  last_up_q,  last_up_d;   // 1 = last direction was up
    logic [NUM_FLOORS-1:0] pending_q,  pending_d;

    logic [NUM_FLOORS-1:0] req_now;     // latched calls plus this edge's calls
    logic [NUM_FLOORS-1:0] above_vec;   // pending calls strictly above the car
    logic [NUM_FLOORS-1:0] below_vec;   // pending calls strictly below the car
    logic [NUM_FLOORS-1:0] clr_mask;    // bit of the floor being serviced
    logic                  any_above;
    logic                  any_below;
    logic [FW-1:0]         floor_up;
    logic [FW-1:0]         floor_dn;

    assign req_now  = pending_q | bus.call_req;
    assign floor_up = floor_q + FW'(1);
    assign floor_dn = floor_q - FW'(1);

    // Per-floor position of each pending call relative to the car, and the
    // clear mask for the floor whose door is (or stays) open after this edge.
    generate
        for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_floor
            assign above_vec[gi] = pending_q[gi] && (FW'(gi) > floor_q);
            assign below_vec[gi] = pending_q[gi] && (FW'(gi) < floor_q);
            assign clr_mask[gi]  = (state_d == S_DOOR) && (floor_d == FW'(gi));
        end
    endgenerate

    assign any_above = |above_vec;
    assign any_below = |below_vec;

    // A call for the floor being serviced is absorbed rather than latched.
    assign pending_d = req_now & ~clr_mask;

    // Next-state logic: IDLE decides on registered pending only, moves step
    // one floor per MOVE_CYCLES, DOOR runs its timer (reloaded by a call for
    // the current floor) and always hands back to IDLE for the next decision.
    always_comb begin
        state_d   = state_q;
        floor_d   = floor_q;
        timer_d   = timer_q;
        last_up_d = last_up_q;

        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (pending_q[floor_q]) begin
                    state_d = S_DOOR;
                end else if (any_above && any_below) begin
                    // Both sides want the car: carry on the way we were going.
                    state_d = last_up_q ? S_MOVE_UP : S_MOVE_DOWN;
                end else if (any_above) begin
                    state_d   = S_MOVE_UP;
                    last_up_d = 1'b1;
                end else if (any_below) begin
                    state_d   = S_MOVE_DOWN;
                    last_up_d = 1'b0;
                end
            end

            S_MOVE_UP: begin
                if (timer_q == MOVE_LAST) begin
                    timer_d = '0;
                    if (floor_q == FLOOR_TOP) begin
                        // Nowhere further to go; let IDLE re-plan.
                        state_d = S_IDLE;
                    end else begin
                        floor_d = floor_up;
                        if (req_now[floor_up]) begin
                            state_d = S_DOOR;
                        end
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            S_MOVE_DOWN: begin
                if (timer_q == MOVE_LAST) begin
                    timer_d = '0;
                    if (floor_q == '0) begin
                        // Already at the ground floor; let IDLE re-plan.
                        state_d = S_IDLE;
                    end else begin
                        floor_d = floor_dn;
                        if (req_now[floor_dn]) begin
                            state_d = S_DOOR;
                        end
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            S_DOOR: begin
                if (bus.call_req[floor_q]) begin
                    // Someone pressed this floor again: restart the door time.
                    timer_d = '0;
                end else if (timer_q == DOOR_LAST) begin
                    timer_d = '0;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase
    end

    // State, position, timer, direction memory and pending calls.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            floor_q   <= '0;
            timer_q   <= '0;
            last_up_q <= 1'b1;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            floor_q   <= floor_d;
            timer_q   <= timer_d;
            last_up_q <= last_up_d;
            pending_q <= pending_d;
        end
    end

    assign bus.floor_bcd = 4'(floor_q);
    assign bus.pending   = pending_q;
    assign bus.dir_up    = (state_q == S_MOVE_UP);
    assign bus.dir_down  = (state_q == S_MOVE_DOWN);
    assign bus.door_open = (state_q == S_DOOR);

endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed bench for elevator_ctrl (6 floors, 4-cycle moves, 3-cycle door).
// Stimulus queues the expected door services; a monitor pops one entry each
// time the door opens and checks floor, pending calls and door duration.
module tb_elevator_ctrl;

    localparam int NF = 6;

    logic clk;
    logic reset;

    elevator_if #(.NUM_FLOORS(NF)) bus ();

    elevator_ctrl #(
        .NUM_FLOORS (NF),
        .MOVE_CYCLES(4),
        .DOOR_CYCLES(3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int floor;
        int dur;
        int pend;
    } exp_t;

    exp_t sb[$];
    int   vectors    = 0;
    int   miscompares = 0;
    bit   in_door    = 1'b0;
    exp_t cur;
    int   door_cnt   = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0d at %0t", name, act, $time);
        end
    endtask

    task automatic expect_door(input int f, input int d, input int p);
        exp_t e;
        e.floor = f;
        e.dur   = d;
        e.pend  = p;
        sb.push_back(e);
    endtask

    task automatic pulse(input logic [NF-1:0] v);
        @(negedge clk);
        bus.call_req = v;
        @(negedge clk);
        bus.call_req = '0;
    endtask

    task automatic wait_idle(input int budget, output bit saw_move);
        int n;
        n = 0;
        saw_move = 1'b0;
        while (n < budget && !(sb.size() == 0 && !in_door && !bus.door_open
                               && !bus.dir_up && !bus.dir_down)) begin
            @(negedge clk);
            n++;
            if (bus.dir_up || bus.dir_down) saw_move = 1'b1;
        end
        check("idle_reached", int'(n < budget), 1);
        @(negedge clk);
    endtask

    task automatic wait_floor(input int f);
        int n;
        n = 0;
        while (n < 200 && int'(bus.floor_bcd) != f) begin
            @(negedge clk);
            n++;
        end
        check("reach_floor", int'(bus.floor_bcd), f);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: one scoreboard entry per door opening.
    initial begin
        forever begin
            @(negedge clk);
            if (in_door) begin
                if (bus.door_open) begin
                    door_cnt++;
                end else begin
                    check("door_cycles", door_cnt, cur.dur);
                    in_door = 1'b0;
                end
            end else if (bus.door_open) begin
                if (sb.size() == 0) begin
                    check("door_unexpected", 1, 0);
                    cur.floor = -1;
                    cur.dur   = -1;
                    cur.pend  = -1;
                end else begin
                    cur = sb.pop_front();
                    check("door_floor", int'(bus.floor_bcd), cur.floor);
                    check("door_pending", int'(bus.pending), cur.pend);
                end
                in_door  = 1'b1;
                door_cnt = 1;
            end
        end
    end

    // Hard stop in case something upstream never settles.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Stimulus.
    initial begin
        bit saw;
        int n;
        bus.call_req = '0;
        reset = 1'b1;

        // Reset held for two edges.
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_floor",   int'(bus.floor_bcd), 0);
        check("rst_pending", int'(bus.pending), 0);
        check("rst_dir_up",  int'(bus.dir_up), 0);
        check("rst_dir_dn",  int'(bus.dir_down), 0);
        check("rst_door",    int'(bus.door_open), 0);
        reset = 1'b0;

        // Call for the floor the car is already on.
        expect_door(0, 3, 0);
        pulse(6'b000001);
        wait_idle(100, saw);
        check("cur_floor_no_move", int'(saw), 0);

        // Single call up to floor 3.
        expect_door(3, 3, 0);
        pulse(6'b001000);
        check("up_pending", int'(bus.pending), 6'b001000);
        @(negedge clk);
        check("up_dir_up", int'(bus.dir_up), 1);
        repeat (4) @(negedge clk);
        check("up_floor1", int'(bus.floor_bcd), 1);
        repeat (4) @(negedge clk);
        check("up_floor2", int'(bus.floor_bcd), 2);
        repeat (4) @(negedge clk);
        check("up_floor3", int'(bus.floor_bcd), 3);
        wait_idle(100, saw);

        // Reset while moving up from floor 3.
        pulse(6'b100000);
        n = 0;
        while (n < 50 && !bus.dir_up) begin
            @(negedge clk);
            n++;
        end
        check("mid_dir_up", int'(bus.dir_up), 1);
        check("mid_floor", int'(bus.floor_bcd), 3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_floor",   int'(bus.floor_bcd), 0);
        check("mid_rst_pending", int'(bus.pending), 0);
        check("mid_rst_dir_up",  int'(bus.dir_up), 0);
        check("mid_rst_dir_dn",  int'(bus.dir_down), 0);
        check("mid_rst_door",    int'(bus.door_open), 0);

        // Heading to 4, call for 2 while passing floor 1.
        expect_door(2, 3, 6'b010000);
        expect_door(4, 3, 0);
        pulse(6'b010000);
        wait_floor(1);
        bus.call_req = 6'b000100;
        @(negedge clk);
        bus.call_req = '0;
        wait_idle(200, saw);

        // LOOK: going up past 2 towards 5, call for 1 placed behind the car.
        do_reset();
        expect_door(5, 3, 6'b000010);
        expect_door(1, 3, 0);
        pulse(6'b100000);
        wait_floor(2);
        check("look_dir_up", int'(bus.dir_up), 1);
        bus.call_req = 6'b000010;
        @(negedge clk);
        bus.call_req = '0;
        wait_idle(300, saw);
        check("look_pending_end", int'(bus.pending), 0);

        // Door re-trigger at floor 2 during the second open cycle.
        expect_door(2, 5, 0);
        pulse(6'b000100);
        n = 0;
        while (n < 50 && !bus.door_open) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        bus.call_req = 6'b000100;
        @(negedge clk);
        bus.call_req = '0;
        check("retrig_pending", int'(bus.pending), 0);
        wait_idle(100, saw);

        // Current floor plus another floor at once: door first, other held.
        expect_door(2, 3, 6'b010000);
        expect_door(4, 3, 0);
        pulse(6'b010100);
        wait_idle(200, saw);

        check("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
